// File: rtl/mem_bank_pkg.sv
// Shared types and helpers for the four-bank main-memory responder.
// Request bundle, bank geometry and address slicing.
package mem_bank_pkg;

  localparam int NUM_BANKS = 4;
  localparam int READ_LAT  = 2;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 16;
  localparam int IDX_W     = 13;
  localparam int SEL_W     = 2;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [SEL_W-1:0]  bank;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] data;
  } mem_req_t;

  function automatic logic [SEL_W-1:0] bank_sel(
    input logic [ADDR_W-1:0] a
  );
    return a[2:1];
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(
    input logic [ADDR_W-1:0] a
  );
    return a[15:3];
  endfunction

endpackage

// File: rtl/four_bank_mem_if.sv
// Request/response bundle between the cache controller and memory.
// master = cache controller side, slave = memory side.
interface four_bank_mem_if;
  import mem_bank_pkg::*;

  logic [ADDR_W-1:0]    addr;
  logic [DATA_W-1:0]    data_in;
  logic                 wr;
  logic                 rd;
  logic [DATA_W-1:0]    data_out;
  logic [NUM_BANKS-1:0] busy;
  logic                 stall;
  logic                 err;

  modport master (
    output addr, data_in, wr, rd,
    input  data_out, busy, stall, err
  );

  modport slave (
    input  addr, data_in, wr, rd,
    output data_out, busy, stall, err
  );

endinterface

// File: rtl/mem_bank.sv
// One word-interleaved bank: storage, occupancy counter and
// the first read-pipeline stage.
module mem_bank
  import mem_bank_pkg::*;
#(
  parameter int BANK_DEPTH = 8192,
  parameter int OCC_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              rd,
  input  logic              wr,
  input  logic [IDX_W-1:0]  index,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  localparam int CW =
    (OCC_CYCLES > 2) ? $clog2(OCC_CYCLES) : 1;
  localparam logic [CW-1:0] OCC_LOAD =
    CW'(OCC_CYCLES - 1);

  logic [DATA_W-1:0] mem [BANK_DEPTH];
  logic [CW-1:0]     cnt;

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[index] <= data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= accept && rd;
      if (accept && rd) begin
        rd_data <= mem[index];
      end
      if (accept) begin
        cnt <= OCC_LOAD;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/four_bank_mem.sv
// Banked main-memory responder: legality check, bank decode,
// stall/err generation and the read-return stage.
module four_bank_mem
  import mem_bank_pkg::*;
#(
  parameter int BANK_DEPTH = 8192,
  parameter int OCC_CYCLES = 4
) (
  input logic           clk,
  input logic           rst,
  four_bank_mem_if.slave bus
);

  mem_req_t             req;
  logic                 any;
  logic                 bad_idx;
  logic                 illegal;
  logic                 legal;
  logic                 accept;
  logic                 tgt_busy;
  logic [NUM_BANKS-1:0] busy;
  logic [NUM_BANKS-1:0] hit;
  logic [NUM_BANKS-1:0] rvalid;
  logic [DATA_W-1:0]    rdata [NUM_BANKS];
  logic [DATA_W-1:0]    mux_data;
  logic [DATA_W-1:0]    s2_data;
  logic                 err_q;

  if (READ_LAT != 2) begin : g_lat_chk
    $error("read path is built for two cycles");
  end

  assign req = '{
    rd:    bus.rd,
    wr:    bus.wr,
    bank:  bank_sel(bus.addr),
    index: word_idx(bus.addr),
    data:  bus.data_in
  };

  // Index range check only exists for shallow banks.
  if (BANK_DEPTH >= (2 ** IDX_W)) begin : g_full
    assign bad_idx = 1'b0;
  end else begin : g_part
    assign bad_idx =
      {{(32-IDX_W){1'b0}}, req.index} >= 32'(BANK_DEPTH);
  end

  assign any      = req.rd | req.wr;
  assign illegal  = any &
    ((req.rd & req.wr) | bus.addr[0] | bad_idx);
  assign legal    = any & ~illegal;
  assign tgt_busy = busy[req.bank];
  assign accept   = legal & ~tgt_busy;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign hit[b] = accept && (req.bank == SEL_W'(b));

    mem_bank #(
      .BANK_DEPTH (BANK_DEPTH),
      .OCC_CYCLES (OCC_CYCLES)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .accept   (hit[b]),
      .rd       (req.rd),
      .wr       (req.wr),
      .index    (req.index),
      .data     (req.data),
      .busy     (busy[b]),
      .rd_valid (rvalid[b]),
      .rd_data  (rdata[b])
    );
  end

  // At most one bank holds a valid stage-1 read.
  always_comb begin
    mux_data = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (rvalid[b]) begin
        mux_data = mux_data | rdata[b];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_data <= '0;
      err_q   <= 1'b0;
    end else begin
      s2_data <= mux_data;
      err_q   <= illegal;
    end
  end

  assign bus.data_out = s2_data;
  assign bus.busy     = busy;
  assign bus.stall    = legal & tgt_busy;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_four_bank_mem.sv
// Bench for four_bank_mem: directed scenarios plus random
// traffic against a cycle-indexed behavioural model.
module tb_four_bank_mem;
  import mem_bank_pkg::*;

  localparam int OCC = 4;

  logic clk;
  logic rst;

  four_bank_mem_if bus();

  four_bank_mem #(
    .BANK_DEPTH (8192),
    .OCC_CYCLES (OCC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int          last_acc [4];
  logic [15:0] mdl      [int];
  logic [15:0] exp_out  [int];
  bit          err_at   [int];

  logic [15:0] e_data;
  logic [3:0]  e_busy;
  logic        e_err;
  logic        e_stall;

  function automatic bit bank_busy(input int b);
    return (cyc > last_acc[b]) &&
           (cyc < last_acc[b] + OCC);
  endfunction

  function automatic bit is_illegal(
    input logic r, input logic w, input logic [15:0] a
  );
    return (r & w) | a[0] | ((a >> 3) >= 8192);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++) last_acc[b] = -100;
    exp_out.delete();
    err_at.delete();
  endtask

  task automatic drive(
    input logic r, input logic w,
    input logic [15:0] a, input logic [15:0] d
  );
    bus.rd      = r;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  // Expected outputs for the current cycle.
  task automatic step();
    bit any;
    @(negedge clk);
    for (int b = 0; b < 4; b++) e_busy[b] = bank_busy(b);
    e_data = exp_out.exists(cyc) ? exp_out[cyc] : 16'h0;
    e_err  = err_at.exists(cyc) ? 1'b1 : 1'b0;
    any = bus.rd | bus.wr;
    e_stall = any &&
      !is_illegal(bus.rd, bus.wr, bus.addr) &&
      e_busy[bus.addr[2:1]];
  endtask

  task automatic advance();
    bit any;
    int b;
    int w;
    if (rst) begin
      any = bus.rd | bus.wr;
      b   = int'(bus.addr[2:1]);
      w   = int'(bus.addr >> 1);
      if (any && is_illegal(bus.rd, bus.wr, bus.addr)) begin
        err_at[cyc + 1] = 1'b1;
      end else if (any && !bank_busy(b)) begin
        last_acc[b] = cyc;
        if (bus.wr) mdl[w] = bus.data_in;
        else exp_out[cyc + 2] = mdl.exists(w) ? mdl[w] : 'x;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    #1 rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (bus.busy !== 4'h0) begin
      errors++;
      $display("FAIL reset_busy got %h exp 0", bus.busy);
    end
    checks++;
    if (bus.data_out !== 16'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", bus.data_out);
    end
    checks++;
    if (bus.err !== 1'b0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_err_stall got %b%b exp 00",
               bus.err, bus.stall);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_write_read();
    for (int i = 0; i < 8; i++) begin
      if (i == 0) drive(1'b0, 1'b1, 16'h0010, 16'hBEEF);
      else if (i == 4) drive(1'b1, 1'b0, 16'h0010, 16'h0);
      else idle();
      step();
      if (i >= 5) begin
        checks++;
        if (bus.data_out !==
            ((i == 6) ? 16'hBEEF : 16'h0)) begin
          errors++;
          $display("FAIL wr_rd_data c%0d got %h", i,
                   bus.data_out);
        end
      end
      if (i == 0 || i == 4) begin
        checks++;
        if (bus.stall !== 1'b0) begin
          errors++;
          $display("FAIL wr_rd_stall c%0d got 1 exp 0", i);
        end
      end
      advance();
    end
  endtask

  task automatic test_bank_conflict();
    logic exp_st;
    logic exp_b1;
    drive(1'b0, 1'b1, 16'h001A, 16'hC0DE);
    step();
    advance();
    for (int i = 0; i < 3; i++) begin
      idle();
      step();
      advance();
    end
    for (int i = 0; i < 12; i++) begin
      case (i)
        0: drive(1'b0, 1'b1, 16'h0002, 16'h1234);
        1: drive(1'b0, 1'b1, 16'h000A, 16'h5678);
        2: drive(1'b0, 1'b1, 16'h001A, 16'hDEAD);
        4: drive(1'b0, 1'b1, 16'h000A, 16'h5678);
        8: drive(1'b1, 1'b0, 16'h001A, 16'h0);
        default: idle();
      endcase
      step();
      exp_st = (i == 1 || i == 2);
      exp_b1 = (i >= 1 && i <= 3) ||
               (i >= 5 && i <= 7) || i >= 9;
      checks++;
      if (bus.stall !== exp_st) begin
        errors++;
        $display("FAIL conf_stall c%0d got %b exp %b",
                 i, bus.stall, exp_st);
      end
      checks++;
      if (bus.busy[1] !== exp_b1) begin
        errors++;
        $display("FAIL conf_busy1 c%0d got %b exp %b",
                 i, bus.busy[1], exp_b1);
      end
      if (i == 10) begin
        checks++;
        if (bus.data_out !== 16'hC0DE) begin
          errors++;
          $display("FAIL conf_nowrite got %h exp c0de",
                   bus.data_out);
        end
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] v [4];
    v[0] = 16'h1111;
    v[1] = 16'h2222;
    v[2] = 16'h3333;
    v[3] = 16'h4444;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) drive(1'b0, 1'b1, 16'(2 * i), v[i]);
      else idle();
      step();
      advance();
    end
    for (int i = 0; i < 7; i++) begin
      if (i < 4) drive(1'b1, 1'b0, 16'(2 * i), 16'h0);
      else idle();
      step();
      checks++;
      if (bus.stall !== 1'b0) begin
        errors++;
        $display("FAIL b2b_stall c%0d got 1 exp 0", i);
      end
      if (i >= 2) begin
        checks++;
        if (bus.data_out !==
            ((i < 6) ? v[i - 2] : 16'h0)) begin
          errors++;
          $display("FAIL b2b_data c%0d got %h", i,
                   bus.data_out);
        end
      end
      advance();
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) drive(1'b1, 1'b1, 16'h0000, 16'h9999);
      else if (i == 2) drive(1'b1, 1'b0, 16'h0003, 16'h0);
      else idle();
      step();
      checks++;
      if (bus.err !== ((i == 1 || i == 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL ill_err c%0d got %b", i, bus.err);
      end
      checks++;
      if (bus.stall !== 1'b0 || bus.busy !== 4'h0 ||
          bus.data_out !== 16'h0) begin
        errors++;
        $display("FAIL ill_quiet c%0d got %b %h %h exp 0 0 0",
                 i, bus.stall, bus.busy, bus.data_out);
      end
      advance();
    end
  endtask

  task automatic test_reset_midread();
    drive(1'b1, 1'b0, 16'h0010, 16'h0);
    step();
    advance();
    idle();
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 2; i++) begin
      step();
      checks++;
      if (bus.busy !== 4'h0 || bus.data_out !== 16'h0 ||
          bus.err !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid c%0d got %h %h %b exp 0 0 0",
                 i, bus.busy, bus.data_out, bus.err);
      end
      advance();
    end
    rst = 1'b1;
    for (int i = 3; i <= 6; i++) begin
      if (i == 3) drive(1'b1, 1'b0, 16'h0010, 16'h0);
      else idle();
      step();
      if (i == 3) begin
        checks++;
        if (bus.stall !== 1'b0) begin
          errors++;
          $display("FAIL rst_rel_stall got 1 exp 0");
        end
      end
      if (i == 4) begin
        checks++;
        if (bus.busy[0] !== 1'b1) begin
          errors++;
          $display("FAIL rst_rel_busy got 0 exp 1");
        end
      end
      if (i >= 4) begin
        checks++;
        if (bus.data_out !==
            ((i == 5) ? 16'hBEEF : 16'h0)) begin
          errors++;
          $display("FAIL rst_rel_data c%0d got %h", i,
                   bus.data_out);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    int op;
    logic [15:0] a;
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, 16'(2 * i), 16'($urandom));
      step();
      advance();
    end
    for (int n = 0; n < 400; n++) begin
      op = $urandom_range(0, 19);
      a  = 16'($urandom_range(0, 15) * 2);
      if ($urandom_range(0, 9) == 0) a[0] = 1'b1;
      if (op < 6) idle();
      else if (op < 12) drive(1'b1, 1'b0, a, 16'($urandom));
      else if (op < 18) drive(1'b0, 1'b1, a, 16'($urandom));
      else drive(1'b1, 1'b1, a, 16'($urandom));
      step();
      checks++;
      if (bus.stall !== e_stall) begin
        errors++;
        $display("FAIL rnd_stall t%0d got %b exp %b",
                 cyc, bus.stall, e_stall);
      end
      checks++;
      if (bus.busy !== e_busy) begin
        errors++;
        $display("FAIL rnd_busy t%0d got %h exp %h",
                 cyc, bus.busy, e_busy);
      end
      checks++;
      if (bus.err !== e_err) begin
        errors++;
        $display("FAIL rnd_err t%0d got %b exp %b",
                 cyc, bus.err, e_err);
      end
      if (!$isunknown(e_data)) begin
        checks++;
        if (bus.data_out !== e_data) begin
          errors++;
          $display("FAIL rnd_data t%0d got %h exp %h",
                   cyc, bus.data_out, e_data);
        end
      end
      advance();
    end
    for (int i = 0; i < 4; i++) begin
      idle();
      step();
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bank_conflict();
    test_back_to_back();
    test_illegal();
    test_reset_midread();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
